// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter slice.
package mem_arb_pkg;

   localparam int unsigned MEM_AW = 4;
   localparam int unsigned MEM_DW = 8;

   typedef enum logic [0:0] {
      StArb    = 1'b0,
      StLocked = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic              we;
      logic [MEM_AW-1:0] addr;
      logic [MEM_DW-1:0] wdata;
   } mem_req_t;

   // Successor of a round-robin index, wrapping from n-1 back to 0.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester channels plus the single memory port, bundled for the arbiter.
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned AW    = MEM_AW,
   parameter int unsigned DW    = MEM_DW
);

   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ-1:0]    req_ready;
   logic [N_REQ-1:0]    req_we;
   logic [N_REQ-1:0]    req_lock;
   logic [N_REQ*AW-1:0] req_addr;
   logic [N_REQ*DW-1:0] req_wdata;
   logic [N_REQ-1:0]    rsp_valid;
   logic [DW-1:0]       rsp_rdata;
   logic                mem_en;
   logic                mem_we;
   logic [AW-1:0]       mem_addr;
   logic [DW-1:0]       mem_wdata;
   logic [DW-1:0]       mem_rdata;

   // Arbiter side.
   modport slave (
      input  req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   // Environment side: requesters and the memory.
   modport master (
      output req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
   parameter int unsigned N    = 2,
   parameter int unsigned IdxW = $clog2(N)
) (
   input  logic [N-1:0]    req_i,
   input  logic [IdxW-1:0] ptr_i,
   output logic [N-1:0]    gnt_o,
   output logic [IdxW-1:0] idx_o,
   output logic            any_o
);

   logic found;

   // Scan N positions starting at the pointer; the first hit wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         int unsigned j;
         j = 32'(ptr_i) + i;
         if (j >= N) j = j - N;
         if (!found && req_i[IdxW'(j)]) begin
            found              = 1'b1;
            gnt_o[IdxW'(j)]    = 1'b1;
            idx_o              = IdxW'(j);
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and access sequencer in front of a single-port memory.
// Optional grant locking for atomic read-modify-write: MEM_ARB_LOCK_EN.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned AW    = MEM_AW,
   parameter int unsigned DW    = MEM_DW
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);

   localparam int unsigned IdW = $clog2(N_REQ);

   arb_state_e     state_q, state_d;
   logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IdW-1:0] lk_id_q, lk_id_d;

   logic [N_REQ-1:0] elig;
   logic [N_REQ-1:0] gnt;
   logic [IdW-1:0]   gnt_idx;
   logic             gnt_any;
   logic             accept;

   logic           mem_en_q, mem_en_d;
   logic           mem_we_q, mem_we_d;
   logic [AW-1:0]  mem_addr_q, mem_addr_d;
   logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
   logic [IdW-1:0] iss_id_q, iss_id_d;
   logic           rd_pend_q, rd_pend_d;
   logic [IdW-1:0] rd_id_q, rd_id_d;

   // While locked only the owner may compete; the picker then finds it directly.
   assign elig = (state_q == StLocked) ? (bus.req_valid & (N_REQ'(1) << lk_id_q))
                                       : bus.req_valid;

   rr_pick #(
      .N    (N_REQ),
      .IdxW (IdW)
   ) u_rr_pick (
      .req_i (elig),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (gnt_any)
   );

   // Grant only depends on valid and state; held low while reset is asserted.
   assign bus.req_ready = reset ? '0 : gnt;
   assign accept        = gnt_any;

`ifndef MEM_ARB_LOCK_EN
   logic unused_lock;
   assign unused_lock = ^bus.req_lock;
`endif

   // Next-state for arbitration state, round-robin pointer and lock owner.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      lk_id_d  = lk_id_q;
`ifdef MEM_ARB_LOCK_EN
      case (state_q)
         StArb: begin
            if (accept) begin
               rr_ptr_d = IdW'(rr_next(32'(gnt_idx), N_REQ));
               if (bus.req_lock[gnt_idx]) begin
                  state_d = StLocked;
                  lk_id_d = gnt_idx;
               end
            end
         end
         StLocked: begin
            // Pointer stays frozen until the owner releases.
            if (accept && !bus.req_lock[gnt_idx]) begin
               state_d  = StArb;
               rr_ptr_d = IdW'(rr_next(32'(lk_id_q), N_REQ));
            end
         end
         default: state_d = StArb;
      endcase
`else
      state_d = StArb;
      lk_id_d = '0;
      if (accept) rr_ptr_d = IdW'(rr_next(32'(gnt_idx), N_REQ));
`endif
   end

   // Arbitration state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StArb;
         rr_ptr_q <= '0;
         lk_id_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         lk_id_q  <= lk_id_d;
      end
   end

   // Issue stage loads the winner's request; address and data hold when idle.
   always_comb begin
      mem_en_d    = accept;
      mem_we_d    = accept & bus.req_we[gnt_idx];
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      iss_id_d    = iss_id_q;
      if (accept) begin
         mem_addr_d  = bus.req_addr[32'(gnt_idx)*AW +: AW];
         mem_wdata_d = bus.req_wdata[32'(gnt_idx)*DW +: DW];
         iss_id_d    = gnt_idx;
      end
      // A read issued this cycle has its data on mem_rdata next cycle.
      rd_pend_d = mem_en_q & ~mem_we_q;
      rd_id_d   = iss_id_q;
   end

   // Issue and read-tracking registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         iss_id_q    <= '0;
         rd_pend_q   <= 1'b0;
         rd_id_q     <= '0;
      end else begin
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         iss_id_q    <= iss_id_d;
         rd_pend_q   <= rd_pend_d;
         rd_id_q     <= rd_id_d;
      end
   end

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.rsp_valid = rd_pend_q ? (N_REQ'(1) << rd_id_q) : '0;
   assign bus.rsp_rdata = bus.mem_rdata;

endmodule
